// File: rtl/itof_arb_pkg.sv
// ============================================================================
// Module      : itof_arb_pkg
// Description : Shared types and constants for the itof_arbiter block:
//               requester tag width, pipeline stage record, latency bounds.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package itof_arb_pkg;

    // Largest supported requester count; the tag is sized for it so that the
    // stage record has one fixed layout for every NREQ.
    localparam int NREQ_MAX = 4;
    localparam int TAG_W    = $clog2(NREQ_MAX);

    // Supported pipeline depth range.
    localparam int LAT_MIN  = 1;
    localparam int LAT_MAX  = 4;

    // One pipeline stage: occupancy, owning requester, converted result.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } stage_t;

endpackage : itof_arb_pkg

`default_nettype wire

// File: rtl/itof.sv
// ============================================================================
// Module      : itof
// Description : Combinational signed int32 to IEEE-754 single conversion,
//               round-to-nearest-even. Zero converts to +0.0.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module itof (
    input  logic [31:0] a_i,
    output logic [31:0] f_o
);

    logic        sign;
    logic [31:0] mag;
    logic [4:0]  msb;
    logic [4:0]  lz;
    logic [30:0] norm;
    logic [7:0]  expo;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [30:0] body;

    // Normalise the magnitude, then round the 23-bit fraction; a carry out
    // of the fraction bumps the exponent through the combined add.
    always_comb begin
        sign = a_i[31];
        mag  = sign ? (~a_i + 32'd1) : a_i;
        msb  = '0;
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) begin
                msb = 5'(i);
            end
        end
        lz       = 5'd31 - msb;
        norm     = 31'(mag << lz);
        expo     = 8'd158 - {3'b000, lz};
        guard    = norm[7];
        sticky   = |norm[6:0];
        round_up = guard & (sticky | norm[8]);
        body     = {expo, norm[30:8]} + {30'b0, round_up};
        if (mag == '0) begin
            f_o = '0;
        end else begin
            f_o = {sign, body};
        end
    end

endmodule : itof

`default_nettype wire

// File: rtl/itof_arbiter_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : NREQ-wide round-robin grant. Searches upward from ptr_i
//               (wrapping), outputs a one-hot grant, its index and the
//               pointer to use after a grant (ptr_i when nothing granted).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import itof_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [TAG_W-1:0] ptr_i,
    input  logic             en_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [TAG_W-1:0] gnt_idx_o,
    output logic [TAG_W-1:0] ptr_next_o
);

    logic found;

    // Two passes: first requesters at or above the pointer, then the wrapped
    // part below it; the first hit in that order wins.
    always_comb begin
        gnt_o      = '0;
        gnt_idx_o  = '0;
        ptr_next_o = ptr_i;
        found      = 1'b0;
        if (en_i) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req_i[i] && (TAG_W'(i) >= ptr_i)) begin
                    found      = 1'b1;
                    gnt_o[i]   = 1'b1;
                    gnt_idx_o  = TAG_W'(i);
                    ptr_next_o = (i == NREQ - 1) ? '0 : TAG_W'(i + 1);
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req_i[i]) begin
                    found      = 1'b1;
                    gnt_o[i]   = 1'b1;
                    gnt_idx_o  = TAG_W'(i);
                    ptr_next_o = (i == NREQ - 1) ? '0 : TAG_W'(i + 1);
                end
            end
        end
    end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/itof_arbiter.sv
// ============================================================================
// Module      : itof_arbiter
// Description : Round-robin sharing of one int-to-float converter among NREQ
//               requesters. Results travel a LAT-deep tagged pipeline whose
//               last stage is the output register, and return to their owner
//               over a valid/ready handshake. The pipeline stalls globally.
//               Optional statistics counters: define ITOF_ARB_STATS_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module itof_arbiter
    import itof_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int LAT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*32-1:0] req_data,
    output logic [NREQ-1:0]   resp_valid,
    input  logic [NREQ-1:0]   resp_ready,
    output logic [31:0]       resp_data,
    output logic              busy
`ifdef ITOF_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0] stat_count,
    output logic [15:0]        stat_stall
`endif
);

    stage_t              stage_q [LAT];
    stage_t              stage0_d;
    stage_t              out_q;
    logic [TAG_W-1:0]    ptr_q;
    logic [TAG_W-1:0]    ptr_d;
    logic [NREQ_MAX-1:0] rr_ext;
    logic                adv;
    logic                arb_en;
    logic [NREQ-1:0]     gnt;
    logic [TAG_W-1:0]    gnt_idx;
    logic                xfer;
    logic [31:0]         sel_data;
    logic [31:0]         conv_data;

    assign out_q = stage_q[LAT-1];

    // Widen resp_ready to the full tag range so any tag value indexes safely.
    always_comb begin
        rr_ext = '0;
        for (int i = 0; i < NREQ; i++) begin
            rr_ext[i] = resp_ready[i];
        end
    end

    // Global advance: output empty or its owner is taking it this cycle.
    assign adv    = !out_q.valid || rr_ext[out_q.tag];
    assign arb_en = adv && !rst;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req_i      (req_valid),
        .ptr_i      (ptr_q),
        .en_i       (arb_en),
        .gnt_o      (gnt),
        .gnt_idx_o  (gnt_idx),
        .ptr_next_o (ptr_d)
    );

    // A grant is only ever issued to a valid requester, so grant == transfer.
    assign req_ready = gnt;
    assign xfer      = |gnt;

    // Operand mux feeding the shared converter.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == TAG_W'(i)) begin
                sel_data = req_data[32*i +: 32];
            end
        end
    end

    itof u_itof (
        .a_i (sel_data),
        .f_o (conv_data)
    );

    // Bubbles carry zero tag/data so idle stages never hold stale results.
    always_comb begin
        stage0_d       = '0;
        stage0_d.valid = xfer;
        if (xfer) begin
            stage0_d.tag  = gnt_idx;
            stage0_d.data = conv_data;
        end
    end

    // Pipeline shift and round-robin pointer; everything holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                stage_q[i] <= '0;
            end
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (adv) begin
                stage_q[0] <= stage0_d;
                for (int i = 1; i < LAT; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end
    end

    // Response routing and occupancy.
    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            resp_valid[i] = out_q.valid && (out_q.tag == TAG_W'(i));
        end
        busy = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            busy = busy | stage_q[i].valid;
        end
    end

    assign resp_data = out_q.data;

`ifdef ITOF_ARB_STATS_EN
    logic [15:0] cnt_q [NREQ];
    logic [15:0] stall_q;

    // Saturating per-requester completion counters and output stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
            end
            stall_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (resp_valid[i] && resp_ready[i] && (cnt_q[i] != 16'hFFFF)) begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end
            end
            if (out_q.valid && !rr_ext[out_q.tag] && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat
        assign stat_count[16*gi +: 16] = cnt_q[gi];
    end

    assign stat_stall = stall_q;
`endif

endmodule : itof_arbiter

`default_nettype wire

// File: tb/tb_itof_arbiter.sv
// ============================================================================
// Module      : tb_itof_arbiter
// Description : Directed self-checking bench for itof_arbiter (NREQ=2, LAT=2).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_itof_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_data;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [31:0] resp_data;
    logic        busy;
`ifdef ITOF_ARB_STATS_EN
    logic [31:0] stat_count;
    logic [15:0] stat_stall;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    itof_arbiter #(
        .NREQ (2),
        .LAT  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy)
`ifdef ITOF_ARB_STATS_EN
        ,
        .stat_count (stat_count),
        .stat_stall (stat_stall)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = 2'b00;
        resp_ready = 2'b11;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        req_valid  = 2'b11;
        req_data   = {32'd5, 32'd6};
        resp_ready = 2'b11;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 2'b00) begin
            n_fail++; $display("FAIL reset_ready0: got %b expected 00", req_ready);
        end
        step();
        @(negedge clk);
        n_tests++;
        if (req_ready !== 2'b00) begin
            n_fail++; $display("FAIL reset_ready1: got %b expected 00", req_ready);
        end
        step();
        rst       = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        n_tests++;
        if (resp_valid !== 2'b00 || busy !== 1'b0 || resp_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_idle: got rv=%b busy=%b data=%h expected rv=00 busy=0 data=00000000",
                     resp_valid, busy, resp_data);
        end
        step();
    endtask

    task automatic test_single();
        req_data[31:0] = 32'd1;
        req_valid      = 2'b01;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 2'b01) begin
            n_fail++; $display("FAIL single_grant: got %b expected 01", req_ready);
        end
        step();
        req_valid = 2'b00;
        @(negedge clk);
        n_tests++;
        if (resp_valid !== 2'b00 || busy !== 1'b1) begin
            n_fail++; $display("FAIL single_mid: got rv=%b busy=%b expected rv=00 busy=1", resp_valid, busy);
        end
        step();
        @(negedge clk);
        n_tests++;
        if (resp_valid !== 2'b01 || resp_data !== 32'h3F800000) begin
            n_fail++; $display("FAIL single_resp: got rv=%b data=%h expected rv=01 data=3f800000", resp_valid, resp_data);
        end
        step();
        @(negedge clk);
        n_tests++;
        if (resp_valid !== 2'b00 || busy !== 1'b0) begin
            n_fail++; $display("FAIL single_drain: got rv=%b busy=%b expected rv=00 busy=0", resp_valid, busy);
        end
    endtask

    task automatic test_two();
        do_reset();
        req_data  = {32'd3, 32'hFFFFFFFF};
        req_valid = 2'b11;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 2'b01) begin
            n_fail++; $display("FAIL two_grant0: got %b expected 01", req_ready);
        end
        step();
        req_valid = 2'b10;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 2'b10) begin
            n_fail++; $display("FAIL two_grant1: got %b expected 10", req_ready);
        end
        step();
        req_valid = 2'b00;
        @(negedge clk);
        n_tests++;
        if (resp_valid !== 2'b01 || resp_data !== 32'hBF800000) begin
            n_fail++; $display("FAIL two_resp0: got rv=%b data=%h expected rv=01 data=bf800000", resp_valid, resp_data);
        end
        step();
        @(negedge clk);
        n_tests++;
        if (resp_valid !== 2'b10 || resp_data !== 32'h40400000) begin
            n_fail++; $display("FAIL two_resp1: got rv=%b data=%h expected rv=10 data=40400000", resp_valid, resp_data);
        end
        step();
    endtask

    task automatic test_alternate();
        logic [31:0] exp_f [8];
        logic [1:0]  exp_g;
        logic [1:0]  exp_v;
        int          cnt0;
        int          cnt1;
        exp_f = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                  32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        cnt0 = 0;
        cnt1 = 0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            req_valid       = (c < 8) ? 2'b11 : 2'b00;
            req_data[31:0]  = 32'(2 * (c / 2) + 1);
            req_data[63:32] = 32'(2 * (c / 2) + 2);
            @(negedge clk);
            if (c < 8) begin
                exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
                n_tests++;
                if (req_ready !== exp_g) begin
                    n_fail++; $display("FAIL alt_grant c=%0d: got %b expected %b", c, req_ready, exp_g);
                end
                if (req_ready[0]) cnt0++;
                if (req_ready[1]) cnt1++;
            end
            if (c >= 2) begin
                exp_v = ((c - 2) % 2 == 0) ? 2'b01 : 2'b10;
                n_tests++;
                if (resp_valid !== exp_v || resp_data !== exp_f[c-2]) begin
                    n_fail++;
                    $display("FAIL alt_resp c=%0d: got rv=%b data=%h expected rv=%b data=%h",
                             c, resp_valid, resp_data, exp_v, exp_f[c-2]);
                end
            end
            step();
        end
        n_tests++;
        if (cnt0 !== 4 || cnt1 !== 4) begin
            n_fail++; $display("FAIL alt_counts: got %0d/%0d expected 4/4", cnt0, cnt1);
        end
    endtask

    task automatic test_stall();
        req_data[63:32] = 32'd0;
        req_valid       = 2'b10;
        resp_ready      = 2'b01;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 2'b10) begin
            n_fail++; $display("FAIL stall_grant: got %b expected 10", req_ready);
        end
        step();
        req_valid = 2'b00;
        step();
        req_valid      = 2'b01;
        req_data[31:0] = 32'd5;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            n_tests++;
            if (resp_valid !== 2'b10 || resp_data !== 32'h0 || req_ready !== 2'b00 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold s=%0d: got rv=%b data=%h rdy=%b busy=%b expected rv=10 data=00000000 rdy=00 busy=1",
                         s, resp_valid, resp_data, req_ready, busy);
            end
            step();
        end
        resp_ready = 2'b11;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 2'b01 || resp_valid !== 2'b10) begin
            n_fail++; $display("FAIL stall_release: got rdy=%b rv=%b expected rdy=01 rv=10", req_ready, resp_valid);
        end
        step();
        req_valid = 2'b00;
        @(negedge clk);
        n_tests++;
        if (resp_valid !== 2'b00 || busy !== 1'b1) begin
            n_fail++; $display("FAIL stall_bubble: got rv=%b busy=%b expected rv=00 busy=1", resp_valid, busy);
        end
        step();
        @(negedge clk);
        n_tests++;
        if (resp_valid !== 2'b01 || resp_data !== 32'h40A00000) begin
            n_fail++; $display("FAIL stall_next: got rv=%b data=%h expected rv=01 data=40a00000", resp_valid, resp_data);
        end
        step();
`ifdef ITOF_ARB_STATS_EN
        @(negedge clk);
        n_tests++;
        if (stat_count !== {16'd5, 16'd5} || stat_stall !== 16'd3) begin
            n_fail++; $display("FAIL stats_accum: got cnt=%h stall=%h expected cnt=00050005 stall=0003", stat_count, stat_stall);
        end
`endif
    endtask

    task automatic test_flush();
        resp_ready = 2'b00;
        req_data   = {32'd8, 32'd7};
        req_valid  = 2'b11;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 2'b10) begin
            n_fail++; $display("FAIL flush_grant0: got %b expected 10", req_ready);
        end
        step();
        @(negedge clk);
        n_tests++;
        if (req_ready !== 2'b01) begin
            n_fail++; $display("FAIL flush_grant1: got %b expected 01", req_ready);
        end
        step();
        rst       = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b1 || resp_valid !== 2'b10) begin
            n_fail++; $display("FAIL flush_inflight: got busy=%b rv=%b expected busy=1 rv=10", busy, resp_valid);
        end
        step();
        rst        = 1'b0;
        resp_ready = 2'b11;
        req_valid  = 2'b11;
        @(negedge clk);
        n_tests++;
        if (resp_valid !== 2'b00 || busy !== 1'b0 || req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL flush_after: got rv=%b busy=%b rdy=%b expected rv=00 busy=0 rdy=01", resp_valid, busy, req_ready);
        end
`ifdef ITOF_ARB_STATS_EN
        n_tests++;
        if (stat_count !== 32'h0 || stat_stall !== 16'h0) begin
            n_fail++; $display("FAIL stats_clear: got cnt=%h stall=%h expected 0", stat_count, stat_stall);
        end
`endif
        step();
        req_valid = 2'b00;
        @(negedge clk);
        n_tests++;
        if (resp_valid !== 2'b00) begin
            n_fail++; $display("FAIL flush_nostale: got rv=%b expected 00", resp_valid);
        end
        step();
        @(negedge clk);
        n_tests++;
        if (resp_valid !== 2'b01 || resp_data !== 32'h40E00000) begin
            n_fail++; $display("FAIL flush_fresh: got rv=%b data=%h expected rv=01 data=40e00000", resp_valid, resp_data);
        end
        step();
    endtask

    task automatic test_rounding();
        logic [31:0] vin  [6];
        logic [31:0] vexp [6];
        vin  = '{32'h00000000, 32'h80000000, 32'h7FFFFFFF, 32'h01000001, 32'h01000003, 32'hFFFFFFF6};
        vexp = '{32'h00000000, 32'hCF000000, 32'h4F000000, 32'h4B800000, 32'h4B800002, 32'hC1200000};
        resp_ready = 2'b11;
        for (int c = 0; c < 8; c++) begin
            req_valid      = (c < 6) ? 2'b01 : 2'b00;
            req_data[31:0] = (c < 6) ? vin[c] : 32'h0;
            @(negedge clk);
            if (c >= 2) begin
                n_tests++;
                if (resp_valid !== 2'b01 || resp_data !== vexp[c-2]) begin
                    n_fail++;
                    $display("FAIL round_%0d: got rv=%b data=%h expected rv=01 data=%h",
                             c - 2, resp_valid, resp_data, vexp[c-2]);
                end
            end
            step();
        end
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 2'b00;
        req_data   = '0;
        resp_ready = 2'b11;
        test_reset();
        test_single();
        test_two();
        test_alternate();
        test_stall();
        test_flush();
        test_rounding();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_itof_arbiter

`default_nettype wire

// File: doc/itof_arbiter.md
Name: itof_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one int-to-float converter datapath (`itof` instance) between NREQ requesters.
- Registers the conversion through a LAT-deep pipeline carrying a requester tag.
- Routes each result back to its owner with a valid/ready handshake.
- Sits between the integer/FPU issue ports and the single conversion resource in the FPU cluster.

Parameters:
- NREQ, 2, number of requesters (2..4).
- LAT, 2, pipeline depth from acceptance to result visible at the output register (1..4); the last stage is the output register.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant/accept; one-hot or zero.
- req_data  in  NREQ*32  packed signed int32 operands; requester i at [32*i+31:32*i].
- resp_valid  out  NREQ  per-requester result valid; one-hot or zero.
- resp_ready  in  NREQ  per-requester result accept.
- resp_data  out  32  IEEE-754 single result, shared bus, meaningful only with resp_valid.
- busy  out  1  any pipeline stage or output register occupied.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - All stage valids and resp_valid clear to 0.
  - resp_data clears to 0.
  - req_ready is 0 while rst is high.
  - RR pointer clears to 0 and busy clears to 0.
  - Reset mid-operation flushes all in-flight ops with no response issued.
- Advance condition: adv = !out_valid || resp_ready[out_tag]. The whole pipeline shifts only when adv=1 (global stall, no bubbles collapsed).
- Arbitration:
  - While adv=1, grant the first requester with req_valid=1, searching from ptr upward modulo NREQ.
  - req_ready[g]=1 combinationally for the granted requester only; req_ready is all-zero when adv=0.
  - req_ready may depend combinationally on req_valid; req_valid must not depend on req_ready.
- Transfer: occurs when req_valid[g] && req_ready[g]. On transfer, ptr <= (g+1) mod NREQ; otherwise ptr holds.
- Datapath and stages:
  - Stage 0 captures {valid, tag, itof(req_data[g])}. The converter is combinational, placed before the stage-0 register.
  - Later stages copy {valid, tag, data} forward.
  - Stage LAT-1 is the output register (out_valid, out_tag, resp_data).
  - If no transfer occurs on an advancing cycle, a bubble (valid=0) enters.
- Latency: result is visible exactly LAT cycles after the accepting edge when there is no stall. Throughput is 1/cycle.
- Response: resp_valid[i] = out_valid && out_tag==i. The result is consumed at the edge where resp_valid[i] && resp_ready[i]; resp_ready of non-owners is ignored.
- Stall: while an output is held, resp_data and resp_valid stay stable, and every stage holds.
- Simultaneous consume + accept: allowed in the same cycle (adv=1 via resp_ready).
- Ordering: results return in acceptance order. With NREQ requesters continuously valid, each receives a grant within NREQ transfers (starvation-free).
- Arithmetic: the converter's rounding and zero handling are reused unchanged. 0 -> 0x00000000; the sign is cleared for zero.
- busy = OR of all stage valids.

Optional Feature:
- Macro ITOF_ARB_STATS_EN.
- Defined:
  - Adds output stat_count, NREQ*16 packed: per-requester count of completed responses, incremented on the response handshake, saturating at 0xFFFF.
  - Adds output stat_stall, 16 bits: cycles with out_valid && !resp_ready[out_tag], saturating.
  - All counters clear on rst.
- Undefined: none of these ports or registers exist; behaviour otherwise identical.

Decomposition:
- Package itof_arb_pkg:
  - TAG_W = $clog2(NREQ max 4) = 2.
  - Typedef stage_t {logic valid; logic [TAG_W-1:0] tag; logic [31:0] data;}.
  - Constants LAT_MIN=1, LAT_MAX=4.
- One natural sub-module: rr_arbiter (NREQ-wide round-robin grant from req vector, ptr and enable; outputs one-hot grant and next ptr). The existing itof is instantiated as the datapath.

Test Plan:
- Reset then idle -> req_ready=0 during rst; after it, resp_valid=0, busy=0, resp_data=0.
- Req0 = 1, LAT=2, resp_ready all 1 -> req_ready[0]=1 at cycle 0; resp_valid=01 and resp_data=0x3F800000 at cycle 2.
- Req0 = -1 and req1 = 3, both valid at cycle 0 with ptr=0 -> req0 granted first, req1 next cycle; responses 0xBF800000 (tag 0) then 0x40400000 (tag 1) on consecutive cycles.
- Both requesters valid continuously for 8 cycles -> grants alternate 0,1,0,1…; each gets exactly 4 transfers; results are in order.
- Req1 = 0 with resp_ready[1]=0 for 3 cycles -> resp_valid=10 held, resp_data=0x00000000 stable, req_ready=00, pipeline frozen; raise resp_ready -> consumed, next op accepted that same cycle.
- rst asserted with 2 ops in flight -> next cycle resp_valid=0, busy=0, ptr=0; no stale result ever appears. With ITOF_ARB_STATS_EN, the stat counters read 0.
